// File: rtl/spi_slave_frame.sv
// spi_slave_frame
//   SPI slave front end. Deserialises a command-prefixed MOSI frame
//   {cmd[1:0], payload[DATA_W-1:0]} into rx_data, and on a read-data command
//   (cmd = 2'b11) waits for the back end to present tx_data, then serialises
//   that word onto MISO.
//
//   Parameters
//     DATA_W    payload width, 4..32 (frame length is DATA_W+2)
//     MSB_FIRST 1: MSB first on MOSI and MISO, 0: LSB first
//
//   Ports
//     clk       system clock, all sampling on the rising edge
//     rst_n     asynchronous active-low reset
//     SS_n      slave select, active low
//     MOSI      serial data in
//     MISO      serial data out (0 outside SHIFT_OUT)
//     rx_data   captured frame {cmd, payload}
//     rx_valid  one-cycle strobe, rx_data valid
//     tx_data   read data from the back end
//     tx_valid  tx_data valid, sampled only in TX_WAIT
//     busy      high whenever the state is not IDLE
//     frame_err one-cycle strobe on an aborted frame
//
//   Build option
//     SPI_SLAVE_FRAME_ERR_EN  when defined, frame_err reports aborted frames;
//                             otherwise frame_err is tied to 0.

module spi_slave_frame #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              busy,
  output logic              frame_err
);

  localparam int FRAME_W = DATA_W + 2;
  localparam int CW      = $clog2(FRAME_W + 1);

  // Count values on the edge that samples the last MOSI bit / has driven the
  // last MISO bit.
  localparam logic [CW-1:0] LAST_IN  = CW'(FRAME_W - 1);
  localparam logic [CW-1:0] LAST_OUT = CW'(DATA_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT_IN,
    S_TX_WAIT,
    S_SHIFT_OUT,
    S_DONE
  } state_t;

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [FRAME_W-1:0]   rx_sh_q;
  logic [FRAME_W-1:0]   rx_data_q;
  logic                 rx_valid_q;
  logic [DATA_W-1:0]    tx_sh_q;
  logic                 miso_q;
  logic                 busy_q;

  logic [FRAME_W-1:0]   rx_seed_d;
  logic [FRAME_W-1:0]   rx_shift_d;
  logic                 tx_first_d;
  logic [DATA_W-1:0]    tx_load_d;
  logic                 tx_bit_d;
  logic [DATA_W-1:0]    tx_shift_d;

  // Bit-order dependent shift paths. LSB-first shifts right so the first
  // received bit ends up in rx_data[0] after FRAME_W samples.
  always_comb begin
    rx_seed_d  = '0;
    rx_shift_d = '0;
    tx_first_d = 1'b0;
    tx_load_d  = '0;
    tx_bit_d   = 1'b0;
    tx_shift_d = '0;
    if (MSB_FIRST) begin
      rx_seed_d  = {{(FRAME_W-1){1'b0}}, MOSI};
      rx_shift_d = {rx_sh_q[FRAME_W-2:0], MOSI};
      tx_first_d = tx_data[DATA_W-1];
      tx_load_d  = tx_data << 1;
      tx_bit_d   = tx_sh_q[DATA_W-1];
      tx_shift_d = tx_sh_q << 1;
    end else begin
      rx_seed_d  = {MOSI, {(FRAME_W-1){1'b0}}};
      rx_shift_d = {MOSI, rx_sh_q[FRAME_W-1:1]};
      tx_first_d = tx_data[0];
      tx_load_d  = tx_data >> 1;
      tx_bit_d   = tx_sh_q[0];
      tx_shift_d = tx_sh_q >> 1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_sh_q    <= '0;
      miso_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!SS_n) begin
            rx_sh_q <= rx_seed_d;
            cnt_q   <= CW'(1);
            state_q <= S_SHIFT_IN;
            busy_q  <= 1'b1;
          end
        end

        S_SHIFT_IN: begin
          // The last bit completes the frame even if SS_n rises on that
          // same edge; the FSM then goes straight back to IDLE.
          if (cnt_q == LAST_IN) begin
            rx_sh_q    <= rx_shift_d;
            rx_data_q  <= rx_shift_d;
            rx_valid_q <= 1'b1;
            cnt_q      <= '0;
            if (SS_n) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else if (rx_shift_d[FRAME_W-1 -: 2] == 2'b11) begin
              state_q <= S_TX_WAIT;
            end else begin
              state_q <= S_DONE;
            end
          end else if (SS_n) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            rx_sh_q <= rx_shift_d;
            cnt_q   <= cnt_q + CW'(1);
          end
        end

        S_TX_WAIT: begin
          if (SS_n) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (tx_valid) begin
            tx_sh_q <= tx_load_d;
            miso_q  <= tx_first_d;
            cnt_q   <= CW'(1);
            state_q <= S_SHIFT_OUT;
          end
        end

        S_SHIFT_OUT: begin
          if (SS_n) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            miso_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (cnt_q == LAST_OUT) begin
            state_q <= S_DONE;
            miso_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            miso_q  <= tx_bit_d;
            tx_sh_q <= tx_shift_d;
            cnt_q   <= cnt_q + CW'(1);
          end
        end

        S_DONE: begin
          if (SS_n) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          miso_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic abort_err_d;
  logic frame_err_q;

  // An abort is only an error while a frame is still incomplete: before the
  // last MOSI bit, while waiting for read data, or before the last MISO bit.
  always_comb begin
    abort_err_d = 1'b0;
    if (SS_n) begin
      case (state_q)
        S_SHIFT_IN:  abort_err_d = (cnt_q != LAST_IN);
        S_TX_WAIT:   abort_err_d = 1'b1;
        S_SHIFT_OUT: abort_err_d = (cnt_q != LAST_OUT);
        default:     abort_err_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= abort_err_d;
    end
  end

  assign frame_err = frame_err_q;
`else
  assign frame_err = 1'b0;
`endif

  assign MISO     = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;

endmodule
